// File: rtl/reg_rename_file_pkg.sv
// Shared defaults and small helpers for the rename-tagged register file.
package reg_rename_file_pkg;

  localparam int DATA_LEN_DEF = 32;
  localparam int REG_LEN_DEF  = 5;
  localparam int ROB_LEN_DEF  = 4;

  // Register index 0 is hard-wired: never read as live, never written.
  function automatic logic is_x0(input logic [REG_LEN_DEF-1:0] idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One dispatcher read port: x0 masking plus same-cycle commit bypass.
module rf_read_port #(
  parameter int DATA_LEN = 32,
  parameter int REG_LEN  = 5,
  parameter int TAG_W    = 5
) (
  input  logic [REG_LEN-1:0]  rs_i,
  input  logic [DATA_LEN-1:0] v_stored_i,
  input  logic [TAG_W-1:0]    q_stored_i,
  input  logic                commit_i,
  input  logic [REG_LEN-1:0]  rd_rob_i,
  input  logic [TAG_W-1:0]    q_rob_i,
  input  logic [DATA_LEN-1:0] v_rob_i,
  output logic [DATA_LEN-1:0] v_o,
  output logic [TAG_W-1:0]    q_o
);

  logic hit;
  assign hit = commit_i && (rd_rob_i == rs_i);

  // A committing value is always forwarded; the tag only clears when the
  // committing entry is still the register's newest producer.
  always_comb begin
    v_o = v_stored_i;
    q_o = q_stored_i;
    if (rs_i == '0) begin
      v_o = '0;
      q_o = '0;
    end else if (hit) begin
      v_o = v_rob_i;
      if (q_stored_i == q_rob_i) q_o = '0;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags, commit bypass,
// misprediction flush and a count of registers awaiting a producer.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int REG_LEN  = REG_LEN_DEF,
  parameter int ROB_LEN  = ROB_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_LEN-1:0]  rs1_from_dsp,
  input  logic [REG_LEN-1:0]  rs2_from_dsp,
  output logic [DATA_LEN-1:0] V1_to_dsp,
  output logic [DATA_LEN-1:0] V2_to_dsp,
  output logic [ROB_LEN:0]    Q1_to_dsp,
  output logic [ROB_LEN:0]    Q2_to_dsp,
  input  logic                ena_from_dsp,
  input  logic [REG_LEN-1:0]  rd_from_dsp,
  input  logic [ROB_LEN:0]    Q_from_dsp,
  input  logic                commit_flag_from_rob,
  input  logic [REG_LEN-1:0]  rd_from_rob,
  input  logic [ROB_LEN:0]    Q_from_rob,
  input  logic [DATA_LEN-1:0] V_from_rob,
  input  logic                flush_from_rob,
  output logic [REG_LEN:0]    pending_cnt
);

  localparam int REG_SIZE = 2 ** REG_LEN;
  localparam int TAG_W    = ROB_LEN + 1;
  localparam logic [REG_LEN:0] CNT_MAX = (REG_LEN+1)'(REG_SIZE - 1);

  logic [REG_SIZE-1:0][DATA_LEN-1:0] v_q, v_d;
  logic [REG_SIZE-1:0][TAG_W-1:0]    q_q, q_d;
  logic [REG_LEN:0]                  cnt_q, cnt_d;

  logic alloc_en, commit_en, commit_match, cnt_inc, cnt_dec;

  // Flush drops a same-cycle allocation; x0 is never a destination.
  assign alloc_en     = ena_from_dsp && (rd_from_dsp != '0) && !flush_from_rob;
  assign commit_en    = commit_flag_from_rob && (rd_from_rob != '0);
  assign commit_match = commit_en && (q_q[rd_from_rob] == Q_from_rob)
                        && (q_q[rd_from_rob] != '0);
  // A zero-tag allocation is malformed: it is written but not counted.
  assign cnt_inc      = alloc_en && (q_q[rd_from_dsp] == '0) && (Q_from_dsp != '0);
  assign cnt_dec      = commit_match && !(alloc_en && (rd_from_dsp == rd_from_rob));

  // Next-state of values and tags; allocation tag overrides a commit clear.
  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (commit_en) v_d[rd_from_rob] = V_from_rob;
    if (flush_from_rob) begin
      q_d = '0;
    end else begin
      if (commit_match) q_d[rd_from_rob] = '0;
      if (alloc_en)     q_d[rd_from_dsp] = Q_from_dsp;
    end
  end

  // Saturating pending counter; flush empties it.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_from_rob)
      cnt_d = '0;
    else if (cnt_inc && !cnt_dec && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
    else if (cnt_dec && !cnt_inc && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // State register with synchronous reset overriding every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  rf_read_port #(.DATA_LEN(DATA_LEN), .REG_LEN(REG_LEN), .TAG_W(TAG_W)) u_rd1 (
    .rs_i       (rs1_from_dsp),
    .v_stored_i (v_q[rs1_from_dsp]),
    .q_stored_i (q_q[rs1_from_dsp]),
    .commit_i   (commit_flag_from_rob),
    .rd_rob_i   (rd_from_rob),
    .q_rob_i    (Q_from_rob),
    .v_rob_i    (V_from_rob),
    .v_o        (V1_to_dsp),
    .q_o        (Q1_to_dsp)
  );

  rf_read_port #(.DATA_LEN(DATA_LEN), .REG_LEN(REG_LEN), .TAG_W(TAG_W)) u_rd2 (
    .rs_i       (rs2_from_dsp),
    .v_stored_i (v_q[rs2_from_dsp]),
    .q_stored_i (q_q[rs2_from_dsp]),
    .commit_i   (commit_flag_from_rob),
    .rd_rob_i   (rd_from_rob),
    .q_rob_i    (Q_from_rob),
    .v_rob_i    (V_from_rob),
    .v_o        (V2_to_dsp),
    .q_o        (Q2_to_dsp)
  );

`ifndef SYNTHESIS
  // Every real producer carries a nonzero ROB tag.
  a_alloc_tag_nonzero: assert property (@(posedge clk) disable iff (rst)
    ena_from_dsp |-> (Q_from_dsp != '0));
`endif

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
Architectural register file with per-register rename tags for the Tomasulo core. It supplies source values and tags to the dispatcher, records the destination tag on allocation, and retires values from the ROB. It generalises the earlier single-commit file:
- parametrised depth and widths;
- hard-wired x0;
- same-cycle commit-to-read bypass;
- misprediction flush of all tags;
- pending-register counter.

Parameters:
DATA_LEN, 32, register value width
REG_LEN, 5, architectural register index width; REG_SIZE = 2**REG_LEN
ROB_LEN, 4, ROB index width; tags are ROB_LEN+1 bits, tag 0 = "no producer", live tags 1..2**ROB_LEN

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rs1_from_dsp  in  REG_LEN  source 1 index
rs2_from_dsp  in  REG_LEN  source 2 index
V1_to_dsp  out  DATA_LEN  source 1 value (combinational)
V2_to_dsp  out  DATA_LEN  source 2 value (combinational)
Q1_to_dsp  out  ROB_LEN+1  source 1 tag, 0 = ready (combinational)
Q2_to_dsp  out  ROB_LEN+1  source 2 tag, 0 = ready (combinational)
ena_from_dsp  in  1  allocate destination this cycle
rd_from_dsp  in  REG_LEN  destination index
Q_from_dsp  in  ROB_LEN+1  ROB tag of new producer (nonzero)
commit_flag_from_rob  in  1  commit this cycle
rd_from_rob  in  REG_LEN  committed destination
Q_from_rob  in  ROB_LEN+1  tag of committing entry
V_from_rob  in  DATA_LEN  committed value
flush_from_rob  in  1  misprediction rollback
pending_cnt  out  REG_LEN+1  number of registers with nonzero tag

Behaviour:
- Reset, synchronous: every V = 0, every Q = 0, pending_cnt = 0.
  - Reset overrides alloc, commit and flush in the same cycle.
  - Reset mid-operation discards all in-flight tags.
- x0:
  - reads always return V = 0, Q = 0;
  - alloc and commit to x0 are ignored;
  - x0 is never counted in pending_cnt.
- Read, zero latency, both ports independent:
  - Base result is {V[rs], Q[rs]}.
  - Bypass: if commit_flag_from_rob, rd_from_rob == rs and Q[rs] == Q_from_rob, output V_from_rob and tag 0.
  - If commit hits rs but tags differ (a younger producer exists), output the stored Q and V_from_rob.
  - Alloc in the same cycle is not visible to reads. The dispatcher reads sources before renaming the destination, so rd == rs still returns the pre-allocation state.
- Alloc (ena_from_dsp, rd != 0): next cycle Q[rd] = Q_from_dsp; V[rd] is unchanged.
- Commit (commit_flag_from_rob, rd != 0):
  - V[rd] = V_from_rob;
  - Q[rd] = 0 only if Q[rd] == Q_from_rob.
- Simultaneous alloc and commit to the same rd: commit V is written; alloc tag wins, so Q[rd] = Q_from_dsp regardless of match.
- Flush: next cycle every Q = 0.
  - Commit in the same cycle still writes its V.
  - Alloc in the same cycle is dropped.
  - pending_cnt becomes 0.
- pending_cnt is a registered counter updated each cycle by:
  - +1 when alloc hits a register whose current Q is 0;
  - -1 when commit clears a matching tag that is not re-allocated that cycle.
  - Alloc plus commit-clear on the same rd is net 0.
  - Alloc to a nonzero-tag register is net 0.
  - Range is 0..REG_SIZE-1; it never wraps.
- Illegal Q_from_dsp == 0 with ena: the write is performed and not counted. Flagged by a simulation-only assertion.

Decomposition:
- Shared defines file (existing): TRUE/FALSE, ZERO_WORD, ZERO_ROB, REG_LEN/ROB_LEN/DATA_LEN defaults.
- One sub-module, rf_read_port, instantiated twice: x0 masking plus commit bypass mux.
- Counter and storage stay in the top module.

Test Plan:
- Reset, then read rs1=3, rs2=0 -> V=0, Q=0 on both ports; pending_cnt=0.
- Alloc x5 tag 2; next cycle read x5 -> Q=2, pending_cnt=1. Commit x5 tag 2 value 0xDEADBEEF -> same-cycle read of x5 gives V=0xDEADBEEF, Q=0; next cycle Q=0, pending_cnt=0.
- Alloc x7 tag 1, then alloc x7 tag 4, then commit x7 tag 1 value 9 -> V[7]=9, Q[7] stays 4, pending_cnt=1.
- Same cycle: alloc x8 tag 6 and commit x8 tag 3 (x8 held tag 3), value 0x55 -> Q[8]=6, V[8]=0x55, pending_cnt unchanged.
- Alloc x1..x4 with tags 1..4 (pending_cnt=4), then flush together with commit x2 tag 2 value 7 and alloc x9 tag 5 -> all Q=0, V[2]=7, Q[9]=0, pending_cnt=0.
- Alloc x0 tag 3 and commit x0 value 0x1234 -> x0 reads V=0, Q=0; pending_cnt unchanged. Assert rst during pending alloc -> next cycle all Q=0, V=0.
